// File: rtl/fp_align_stage_pkg.sv
// -----------------------------------------------------------------------------
// fp_align_stage_pkg
// Shared binary32 definitions for the FP alignment front end.
//   - Format widths (exponent, mantissa with hidden bit, fraction, word).
//   - Canonical quiet NaN and an infinity builder.
//   - fp_unpacked_t: one operand after field extraction.
//   - fp_align_res_t: the registered result of the compare/swap stage.
// -----------------------------------------------------------------------------
package fp_align_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 24;
  localparam int unsigned FRAC_W = MAN_W - 1;

  localparam logic [WORD_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  EXP_MAX   = 8'hFF;

  // One operand with hidden bit restored and denormal exponent fixed to 1.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             is_nan;
    logic             is_inf;
  } fp_unpacked_t;

  // Everything the downstream shifter/adder needs for one aligned pair.
  typedef struct packed {
    logic [MAN_W-1:0]  man_big;
    logic [MAN_W-1:0]  man_small;
    logic [EXP_W-1:0]  shift_amt;
    logic [EXP_W-1:0]  exp_big;
    logic              sign_big;
    logic              eff_sub;
    logic              is_special;
    logic [WORD_W-1:0] special_res;
  } fp_align_res_t;

  // Signed infinity word.
  function automatic logic [WORD_W-1:0] fp32_inf(input logic sign);
    return {sign, EXP_MAX, {FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// -----------------------------------------------------------------------------
// fp_unpack
// Splits a binary32 word into sign, effective exponent, 24-bit mantissa and
// NaN/Inf flags. Purely combinational.
//   i_word : binary32 operand
//   o_op   : unpacked operand
// A zero exponent field yields hidden bit 0 and effective exponent 1 so that
// denormals line up with the smallest normal exponent.
// -----------------------------------------------------------------------------
module fp_unpack
  import fp_align_stage_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output fp_unpacked_t      o_op
);

  logic [EXP_W-1:0]  w_exp_field;
  logic [FRAC_W-1:0] w_frac;
  logic              w_exp_zero;
  logic              w_exp_max;
  logic              w_frac_zero;

  assign w_exp_field = i_word[WORD_W-2 -: EXP_W];
  assign w_frac      = i_word[FRAC_W-1:0];
  assign w_exp_zero  = (w_exp_field == '0);
  assign w_exp_max   = (w_exp_field == EXP_MAX);
  assign w_frac_zero = (w_frac == '0);

  always_comb begin
    o_op        = '0;
    o_op.sign   = i_word[WORD_W-1];
    o_op.exp    = w_exp_zero ? EXP_W'(1) : w_exp_field;
    o_op.man    = {~w_exp_zero, w_frac};
    o_op.is_nan = w_exp_max & ~w_frac_zero;
    o_op.is_inf = w_exp_max & w_frac_zero;
  end

endmodule

// File: rtl/fp_align_stage.sv
// -----------------------------------------------------------------------------
// fp_align_stage
// Two-stage front end of an FP32 adder: unpacks both operands, picks the
// larger magnitude, computes the exponent difference for the mantissa
// shifter and resolves NaN/Inf results.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand pair handshake
//   in_a, in_b           binary32 operands
//   in_sub               1 = a - b, 0 = a + b
//   out_valid/out_ready  result handshake
//   man_big, man_small   larger / smaller magnitude mantissas (unshifted)
//   shift_amt            exp_big - exp_small, 0..254
//   exp_big              effective exponent of the larger operand
//   sign_big             sign of the larger operand (b sign includes in_sub)
//   eff_sub              effective subtraction
//   is_special           special_res is the final answer
//   special_res          NaN/Inf result word, 0 when not special
//
// Stage 1 registers the unpacked operands; stage 2 registers the result.
// Both stages advance together whenever the output is not stalled, so a
// pair takes exactly two cycles and throughput is one pair per cycle.
// -----------------------------------------------------------------------------
module fp_align_stage
  import fp_align_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAN_W-1:0]  man_big,
  output logic [MAN_W-1:0]  man_small,
  output logic [EXP_W-1:0]  shift_amt,
  output logic [EXP_W-1:0]  exp_big,
  output logic              sign_big,
  output logic              eff_sub,
  output logic              is_special,
  output logic [WORD_W-1:0] special_res
);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_stall;
  logic w_advance;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_stall   = r_s2_valid & ~out_ready;
  assign w_advance = ~w_stall;
  assign in_ready  = w_advance;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack and register
  // ---------------------------------------------------------------------------
  fp_unpacked_t w_op_a;
  fp_unpacked_t w_op_b;
  fp_unpacked_t r_s1_a;
  fp_unpacked_t r_s1_b;
  logic         r_s1_sub;

  fp_unpack u_unpack_a (
    .i_word (in_a),
    .o_op   (w_op_a)
  );

  fp_unpack u_unpack_b (
    .i_word (in_b),
    .o_op   (w_op_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sub   <= 1'b0;
    end else if (w_advance) begin
      // A low in_valid here leaves a bubble behind in stage 1.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= w_op_a;
        r_s1_b   <= w_op_b;
        r_s1_sub <= in_sub;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: compare / swap / special resolution
  // ---------------------------------------------------------------------------
  logic          w_sign_b_eff;
  logic          w_eff_sub;
  logic          w_a_big;
  logic          w_any_nan;
  logic          w_inf_cancel;
  fp_align_res_t w_res;
  fp_align_res_t r_s2_res;

  // Subtraction is folded into b's sign before anything looks at signs.
  assign w_sign_b_eff = r_s1_b.sign ^ r_s1_sub;
  assign w_eff_sub    = r_s1_a.sign ^ w_sign_b_eff;

  // Magnitude order on {exp, man}; equal magnitudes keep a as the big one.
  assign w_a_big = ({r_s1_a.exp, r_s1_a.man} >= {r_s1_b.exp, r_s1_b.man});

  assign w_any_nan    = r_s1_a.is_nan | r_s1_b.is_nan;
  assign w_inf_cancel = r_s1_a.is_inf & r_s1_b.is_inf & w_eff_sub;

  always_comb begin
    w_res         = '0;
    w_res.eff_sub = w_eff_sub;

    if (w_a_big) begin
      w_res.man_big   = r_s1_a.man;
      w_res.man_small = r_s1_b.man;
      w_res.exp_big   = r_s1_a.exp;
      w_res.shift_amt = r_s1_a.exp - r_s1_b.exp;
      w_res.sign_big  = r_s1_a.sign;
    end else begin
      w_res.man_big   = r_s1_b.man;
      w_res.man_small = r_s1_a.man;
      w_res.exp_big   = r_s1_b.exp;
      w_res.shift_amt = r_s1_b.exp - r_s1_a.exp;
      w_res.sign_big  = w_sign_b_eff;
    end

    // NaN and Inf-Inf beat a lone Inf; a's Inf wins when both are Inf.
    if (w_any_nan || w_inf_cancel) begin
      w_res.is_special  = 1'b1;
      w_res.special_res = FP32_QNAN;
    end else if (r_s1_a.is_inf) begin
      w_res.is_special  = 1'b1;
      w_res.special_res = fp32_inf(r_s1_a.sign);
    end else if (r_s1_b.is_inf) begin
      w_res.is_special  = 1'b1;
      w_res.special_res = fp32_inf(w_sign_b_eff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res <= w_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid   = r_s2_valid;
  assign man_big     = r_s2_res.man_big;
  assign man_small   = r_s2_res.man_small;
  assign shift_amt   = r_s2_res.shift_amt;
  assign exp_big     = r_s2_res.exp_big;
  assign sign_big    = r_s2_res.sign_big;
  assign eff_sub     = r_s2_res.eff_sub;
  assign is_special  = r_s2_res.is_special;
  assign special_res = r_s2_res.special_res;

endmodule

// File: tb/tb_fp_align_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_align_stage
// Scoreboard bench for fp_align_stage: expected results are computed from the
// operand words when a pair is accepted and compared when the DUT presents
// them; a two-bit occupancy model predicts out_valid and in_ready each cycle.
// -----------------------------------------------------------------------------
module tb_fp_align_stage;

  typedef struct {
    logic [23:0] mb;
    logic [23:0] ms;
    logic [7:0]  sh;
    logic [7:0]  eb;
    logic        sb;
    logic        es;
    logic        sp;
    logic [31:0] sr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] man_big;
  logic [23:0] man_small;
  logic [7:0]  shift_amt;
  logic [7:0]  exp_big;
  logic        sign_big;
  logic        eff_sub;
  logic        is_special;
  logic [31:0] special_res;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic m_v1 = 1'b0;
  logic m_v2 = 1'b0;

  fp_align_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sub      (in_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .man_big     (man_big),
    .man_small   (man_small),
    .shift_amt   (shift_amt),
    .exp_big     (exp_big),
    .sign_big    (sign_big),
    .eff_sub     (eff_sub),
    .is_special  (is_special),
    .special_res (special_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp_v);
    end
  endtask

  // Reference: value-level view of the two binary32 words.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    exp_t        e;
    logic [7:0]  fa, fb, xa, xb;
    logic [23:0] ma, mb;
    logic        sgb, a_wins, na, nb, ia, ib;
    fa  = a[30:23];
    fb  = b[30:23];
    xa  = (fa == 8'd0) ? 8'd1 : fa;
    xb  = (fb == 8'd0) ? 8'd1 : fb;
    ma  = {(fa != 8'd0), a[22:0]};
    mb  = {(fb != 8'd0), b[22:0]};
    sgb = b[31] ^ sub;
    e.es = a[31] ^ sgb;
    a_wins = (xa > xb) || ((xa == xb) && (ma >= mb));
    if (a_wins) begin
      e.mb = ma; e.ms = mb; e.eb = xa; e.sh = xa - xb; e.sb = a[31];
    end else begin
      e.mb = mb; e.ms = ma; e.eb = xb; e.sh = xb - xa; e.sb = sgb;
    end
    na = (fa == 8'hFF) && (a[22:0] != 23'd0);
    nb = (fb == 8'hFF) && (b[22:0] != 23'd0);
    ia = (fa == 8'hFF) && (a[22:0] == 23'd0);
    ib = (fb == 8'hFF) && (b[22:0] == 23'd0);
    e.sp = 1'b1;
    if (na || nb || (ia && ib && e.es)) e.sr = 32'h7FC0_0000;
    else if (ia)                         e.sr = {a[31], 8'hFF, 23'd0};
    else if (ib)                         e.sr = {sgb, 8'hFF, 23'd0};
    else begin
      e.sp = 1'b0;
      e.sr = 32'd0;
    end
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, check 1 ns later.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic ordy, output logic acc);
    exp_t h;
    logic stall;
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    stall = m_v2 && !ordy;
    check("out_valid", 32'(out_valid), 32'(m_v2));
    check("in_ready", 32'(in_ready), 32'(!stall));
    if (m_v2) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: result expected but queue empty");
      end else begin
        h = sb_q[0];
        if (!h.sp) begin
          check("man_big", 32'(man_big), 32'(h.mb));
          check("man_small", 32'(man_small), 32'(h.ms));
        end
        check("shift_amt", 32'(shift_amt), 32'(h.sh));
        check("exp_big", 32'(exp_big), 32'(h.eb));
        check("sign_big", 32'(sign_big), 32'(h.sb));
        check("eff_sub", 32'(eff_sub), 32'(h.es));
        check("is_special", 32'(is_special), 32'(h.sp));
        check("special_res", special_res, h.sr);
        if (ordy) void'(sb_q.pop_front());
      end
    end
    acc = iv && !stall;
    if (acc) sb_q.push_back(model(a, b, sub));
    if (!stall) begin
      m_v2 = m_v1;
      m_v1 = acc;
    end
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 20 && (sb_q.size() != 0 || m_v2 || m_v1); c++)
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic acc;
    cycle(1'b1, a, b, sub, 1'b1, acc);
    check("accept", 32'(acc), 32'd1);
    drain();
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0]  e;
    logic [22:0] f;
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 3));
      3:       e = 8'hFE;
      default: e = 8'($urandom_range(100, 154));
    endcase
    f = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] st_a[4] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h0000_0001, 32'hC040_0000};
  logic [31:0] st_b[4] = '{32'h4000_0000, 32'h3FE0_0000, 32'h0080_0000, 32'h40A0_0000};
  logic        st_s[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic        acc;
    logic        have;
    logic        ordy;
    logic [31:0] ra, rb;
    logic        rs;
    int          idx;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_is_special", 32'(is_special), 32'd0);
    check("rst_special_res", special_res, 32'd0);
    check("rst_man_big", 32'(man_big), 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    send_one(32'h3F80_0000, 32'h4000_0000, 1'b0);
    send_one(32'h3FC0_0000, 32'h3FE0_0000, 1'b1);
    send_one(32'h0000_0001, 32'h0080_0000, 1'b0);
    send_one(32'h7F80_0000, 32'h7F80_0000, 1'b1);
    send_one(32'hFF80_0000, 32'h3F80_0000, 1'b0);
    send_one(32'h3F80_0000, 32'h7F80_0000, 1'b1);
    send_one(32'h7FC1_2345, 32'h3F80_0000, 1'b0);
    send_one(32'h4040_0000, 32'h4040_0000, 1'b1);
    send_one(32'h7F7F_FFFF, 32'h0000_0000, 1'b0);

    // Back-to-back stream of four, out_ready low on cycles 3..5.
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || sb_q.size() != 0); c++) begin
      ordy = !(c >= 3 && c <= 5);
      if (idx < 4) cycle(1'b1, st_a[idx], st_b[idx], st_s[idx], ordy, acc);
      else         cycle(1'b0, 32'd0, 32'd0, 1'b0, ordy, acc);
      if (acc) idx++;
    end
    check("stream_sent", 32'(idx), 32'd4);
    drain();

    // Random traffic with random bubbles and back-pressure.
    have = 1'b0;
    ra = 32'd0; rb = 32'd0; rs = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ra   = rand_word();
        rb   = ($urandom_range(0, 7) == 0) ? ra : rand_word();
        rs   = 1'($urandom);
        have = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(have, ra, rb, rs, ordy, acc);
      if (acc) have = 1'b0;
    end
    drain();

    // Reset with two pairs in flight.
    cycle(1'b1, 32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_special", 32'(is_special), 32'd0);
    check("async_rst_res", special_res, 32'd0);
    sb_q.delete();
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    send_one(32'h4049_0FDB, 32'h3F80_0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_align_stage.md
FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 Parameters: none; fixed IEEE-754 binary32 format, 24-bit mantissa with hidden bit, 8-bit shift amount.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  stage accepts the pair this cycle.
REQ-006 in_a, in_b  input  32 each  binary32 operands.
REQ-007 in_sub  input  1  1 = compute a-b, 0 = a+b.
REQ-008 out_valid  output  1  aligned result present.
REQ-009 out_ready  input  1  downstream (mantissa right shifter / adder) accepts.
REQ-010 man_big, man_small  output  24 each  larger-magnitude and smaller-magnitude mantissas, hidden bit included; man_small is unshifted.
REQ-011 shift_amt  output  8  exponent difference; drives the shifter amount input directly.
REQ-012 exp_big  output  8  effective exponent of the larger operand.
REQ-013 sign_big  output  1  sign of larger operand after in_sub is applied to b.
REQ-014 eff_sub  output  1  effective subtraction = sign_a XOR sign_b XOR in_sub.
REQ-015 is_special  output  1  special_res is the final result; mantissa outputs are don't-care.
REQ-016 special_res  output  32  NaN/Inf result word.

Function
REQ-017 Fixed two-stage pipeline; latency 2 cycles from accepted input to out_valid with no stall.
REQ-018 Stage 1 registers unpacked fields: sign, effective exponent, 24-bit mantissa, NaN/Inf flags per operand, and in_sub.
REQ-019 Exponent field 0: hidden bit 0, effective exponent 1 (denormals aligned correctly); otherwise hidden bit 1.
REQ-020 Stage 2 compares {exp,man}; the larger magnitude becomes "big", with a winning ties; shift_amt = exp_big - exp_small, range 0..254, no clamping.
REQ-021 b's sign is inverted when in_sub=1 before the sign and eff_sub computations.
REQ-022 Special priority: any NaN, or Inf minus Inf under eff_sub, gives special_res=0x7FC00000; otherwise any Inf gives the signed Inf of that operand; otherwise is_special=0 and special_res=0.
REQ-023 Handshake: stall = out_valid AND NOT out_ready; in_ready = NOT stall; both stages advance together when not stall.
REQ-024 A transfer occurs only when valid AND ready are both high in the same cycle; in_valid=0 during an advance inserts a bubble (valid bit 0).
REQ-025 While stalled, all outputs hold stable and input data is ignored.
REQ-026 Simultaneous output drain and input accept in one cycle gives full throughput of 1 pair per cycle.

Reset
REQ-027 rst_n low asynchronously clears both stage valid bits and all output registers to 0, including out_valid, is_special and special_res.
REQ-028 Reset mid-operation discards in-flight pairs; in_ready=1 from the first cycle after release.

Structure
REQ-029 The shared FP package holds FP32_QNAN=0x7FC00000, EXP_W=8, MAN_W=24, and a packed unpacked-operand struct {sign, exp, man, is_nan, is_inf}.
REQ-030 One sub-module, fp_unpack, is instantiated once per operand; the compare/swap logic stays in the top module.

Verification
REQ-031 a=0x3F800000, b=0x40000000, in_sub=0 -> after 2 cycles: man_big=0x800000, man_small=0x800000, shift_amt=1, exp_big=0x80, sign_big=0, eff_sub=0.
REQ-032 a=0x3FC00000, b=0x3FE00000, in_sub=1 -> man_big=0xE00000, man_small=0xC00000, shift_amt=0, sign_big=1, eff_sub=1.
REQ-033 a=0x00000001, b=0x00800000 -> man_big=0x800000, man_small=0x000001, shift_amt=0, exp_big=1.
REQ-034 a=0x7F800000, b=0x7F800000, in_sub=1 -> is_special=1, special_res=0x7FC00000; a=0xFF800000, b=0x3F800000 -> special_res=0xFF800000.
REQ-035 Back-to-back stream of 4 pairs with out_ready low for cycles 3-5 -> outputs frozen, in_ready=0 during the stall, all 4 results delivered in order with none lost or duplicated.
REQ-036 Assert rst_n low with 2 pairs in flight -> out_valid=0 immediately; no stale result appears after release.
